// File: rtl/ctrl_unit_fsm_if.sv
// Memory handshake between the control unit and the memory interface.
// The control unit requests (mem_req/mem_rw); memory answers with mem_done.
interface ctrl_unit_fsm_if;
    logic mem_req;
    logic mem_rw;
    logic mem_done;

    modport master (
        output mem_req,
        output mem_rw,
        input  mem_done
    );

    modport slave (
        input  mem_req,
        input  mem_rw,
        output mem_done
    );
endinterface

// File: rtl/ctrl_unit_fsm.sv
// Multicycle control FSM for the ARM-like core: fetch, decode, data-processing,
// load/store word and branch/branch-with-link, driving all mux selects and strobes.
module ctrl_unit_fsm #(
    parameter logic [3:0] OP_ADD   = 4'b0100,
    parameter logic [3:0] OP_SUB   = 4'b0010,
    parameter logic [3:0] OP_PASSA = 4'b1110,
    parameter logic [3:0] OP_PASSB = 4'b1101
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ir,
    input  logic              cond_ok,
    ctrl_unit_fsm_if.master   mem,
    output logic [1:0]        ma,
    output logic [1:0]        mb,
    output logic [2:0]        mc,
    output logic              md,
    output logic              me,
    output logic              mf,
    output logic              mg,
    output logic              mh,
    output logic [1:0]        mi,
    output logic [1:0]        mj,
    output logic [3:0]        op,
    output logic              ld_rf,
    output logic              ld_ir,
    output logic              ld_mar,
    output logic              ld_mdr,
    output logic              ld_flags,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH0  = 4'd1,
        FETCH1  = 4'd2,
        FETCH2  = 4'd3,
        DECODE  = 4'd4,
        DP      = 4'd5,
        LS_ADDR = 4'd6,
        LD_WAIT = 4'd7,
        LD_WB   = 4'd8,
        ST_DATA = 4'd9,
        ST_WAIT = 4'd10,
        BR      = 4'd11,
        BR_LINK = 4'd12
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic mem_req;
    logic mem_rw;
    logic mem_done;

    // Only the class, U, L, S and I bits steer the sequence.
    logic unused_ir;
    assign unused_ir = ^{ir[31:28], ir[22:21], ir[19:0], OP_PASSB};

    assign mem_done    = mem.mem_done;
    assign mem.mem_req = mem_req;
    assign mem.mem_rw  = mem_rw;

    assign me    = 1'b0;
    assign mi    = 2'd0;
    assign mj    = 2'd0;
    assign state = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        ma        = 2'd0;
        mb        = 2'd0;
        mc        = 3'd0;
        md        = 1'b0;
        mf        = 1'b0;
        mg        = 1'b0;
        mh        = 1'b0;
        op        = 4'd0;
        ld_rf     = 1'b0;
        ld_ir     = 1'b0;
        ld_mar    = 1'b0;
        ld_mdr    = 1'b0;
        ld_flags  = 1'b0;
        mem_req   = 1'b0;
        mem_rw    = 1'b0;

        case (cur_state)
            IDLE: begin
                nxt_state = FETCH0;
            end

            FETCH0: begin
                ma        = 2'd2;
                md        = 1'b1;
                op        = OP_PASSA;
                ld_mar    = 1'b1;
                nxt_state = FETCH1;
            end

            // PC+4 written back while the instruction read is launched.
            FETCH1: begin
                ma        = 2'd2;
                mb        = 2'd2;
                md        = 1'b1;
                op        = OP_ADD;
                mc        = 3'd3;
                ld_rf     = 1'b1;
                mem_req   = 1'b1;
                mem_rw    = 1'b1;
                nxt_state = FETCH2;
            end

            FETCH2: begin
                mem_req = 1'b1;
                mem_rw  = 1'b1;
                ld_ir   = mem_done;
                if (mem_done) begin
                    nxt_state = DECODE;
                end
            end

            DECODE: begin
                if (!cond_ok) begin
                    nxt_state = FETCH0;
                end else if (ir[27:26] == 2'b00) begin
                    nxt_state = DP;
                end else if (ir[27:26] == 2'b01) begin
                    nxt_state = LS_ADDR;
                end else if (ir[27:25] == 3'b101) begin
                    nxt_state = ir[24] ? BR_LINK : BR;
                end else begin
                    nxt_state = FETCH0;
                end
            end

            // TST/TEQ/CMP/CMN (opcode 10xx) only update flags.
            DP: begin
                ma        = 2'd0;
                mb        = ir[25] ? 2'd1 : 2'd0;
                md        = 1'b0;
                mc        = 3'd1;
                mg        = 1'b0;
                ld_rf     = (ir[24:23] != 2'b10);
                ld_flags  = ir[20];
                nxt_state = FETCH0;
            end

            LS_ADDR: begin
                ma        = 2'd0;
                mb        = 2'd1;
                md        = 1'b1;
                op        = ir[23] ? OP_ADD : OP_SUB;
                ld_mar    = 1'b1;
                nxt_state = ir[20] ? LD_WAIT : ST_DATA;
            end

            LD_WAIT: begin
                mem_req = 1'b1;
                mem_rw  = 1'b1;
                mf      = 1'b1;
                ld_mdr  = mem_done;
                if (mem_done) begin
                    nxt_state = LD_WB;
                end
            end

            LD_WB: begin
                mg        = 1'b1;
                mc        = 3'd1;
                ld_rf     = 1'b1;
                nxt_state = FETCH0;
            end

            ST_DATA: begin
                ma        = 2'd1;
                md        = 1'b1;
                op        = OP_PASSA;
                mf        = 1'b0;
                ld_mdr    = 1'b1;
                nxt_state = ST_WAIT;
            end

            ST_WAIT: begin
                mem_req = 1'b1;
                mem_rw  = 1'b0;
                if (mem_done) begin
                    nxt_state = FETCH0;
                end
            end

            BR_LINK: begin
                ma        = 2'd2;
                md        = 1'b1;
                op        = OP_PASSA;
                mc        = 3'd2;
                ld_rf     = 1'b1;
                nxt_state = BR;
            end

            BR: begin
                ma        = 2'd2;
                mh        = 1'b1;
                md        = 1'b1;
                op        = OP_ADD;
                mc        = 3'd3;
                ld_rf     = 1'b1;
                nxt_state = FETCH0;
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_unit_fsm.sv
// Randomized bench for ctrl_unit_fsm: per-instruction phase plans and
// latency formulas are compared cycle by cycle against the DUT.
module tb_ctrl_unit_fsm;

    localparam int P_IDLE = 0;
    localparam int P_F0   = 1;
    localparam int P_F1   = 2;
    localparam int P_F2   = 3;
    localparam int P_DEC  = 4;
    localparam int P_DP   = 5;
    localparam int P_LSA  = 6;
    localparam int P_LDW  = 7;
    localparam int P_LWB  = 8;
    localparam int P_STD  = 9;
    localparam int P_STW  = 10;
    localparam int P_BR   = 11;
    localparam int P_BL   = 12;

    localparam logic [3:0] ADD   = 4'b0100;
    localparam logic [3:0] SUB   = 4'b0010;
    localparam logic [3:0] PASSA = 4'b1110;

    localparam int NINST = 300;
    localparam int NDIR  = 7;

    logic        clk;
    logic        rst_n;
    logic [31:0] ir;
    logic        cond_ok;
    logic [1:0]  ma, mb, mi, mj;
    logic [2:0]  mc;
    logic        md, me, mf, mg, mh;
    logic [3:0]  op;
    logic        ld_rf, ld_ir, ld_mar, ld_mdr, ld_flags;
    logic [3:0]  state;

    ctrl_unit_fsm_if bus ();

    ctrl_unit_fsm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ir       (ir),
        .cond_ok  (cond_ok),
        .mem      (bus),
        .ma       (ma),
        .mb       (mb),
        .mc       (mc),
        .md       (md),
        .me       (me),
        .mf       (mf),
        .mg       (mg),
        .mh       (mh),
        .mi       (mi),
        .mj       (mj),
        .op       (op),
        .ld_rf    (ld_rf),
        .ld_ir    (ld_ir),
        .ld_mar   (ld_mar),
        .ld_mdr   (ld_mdr),
        .ld_flags (ld_flags),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {5'd0, ma, mb, mc, md, me, mf, mg, mh, mi, mj, op,
                ld_rf, ld_ir, ld_mar, ld_mdr, ld_flags,
                bus.mem_req, bus.mem_rw};
    endfunction

    // Expected outputs for one phase of an instruction, from the spec table.
    function automatic logic [31:0] exp_vec(input int ph, input logic [31:0] i,
                                            input logic done);
        logic [1:0] a, b;
        logic [2:0] c;
        logic       d, f, g, h, rf, irl, mar, mdr, fl, rq, rw;
        logic [3:0] o;
        a = 0; b = 0; c = 0; d = 0; f = 0; g = 0; h = 0; o = 0;
        rf = 0; irl = 0; mar = 0; mdr = 0; fl = 0; rq = 0; rw = 0;
        case (ph)
            P_F0:  begin a = 2; d = 1; o = PASSA; mar = 1; end
            P_F1:  begin a = 2; b = 2; d = 1; o = ADD; c = 3; rf = 1; rq = 1; rw = 1; end
            P_F2:  begin rq = 1; rw = 1; irl = done; end
            P_DP:  begin
                b  = i[25] ? 2'd1 : 2'd0;
                c  = 1;
                rf = !(i[24] && !i[23]);
                fl = i[20];
            end
            P_LSA: begin b = 1; d = 1; o = i[23] ? ADD : SUB; mar = 1; end
            P_LDW: begin rq = 1; rw = 1; f = 1; mdr = done; end
            P_LWB: begin g = 1; c = 1; rf = 1; end
            P_STD: begin a = 1; d = 1; o = PASSA; mdr = 1; end
            P_STW: begin rq = 1; end
            P_BL:  begin a = 2; d = 1; o = PASSA; c = 2; rf = 1; end
            P_BR:  begin a = 2; h = 1; d = 1; o = ADD; c = 3; rf = 1; end
            default: ;
        endcase
        return {5'd0, a, b, c, d, 1'b0, f, g, h, 2'd0, 2'd0, o,
                rf, irl, mar, mdr, fl, rq, rw};
    endfunction

    function automatic bit is_wait(input int ph);
        return ph == P_F2 || ph == P_LDW || ph == P_STW;
    endfunction

    logic [31:0] dir_ir [NDIR] = '{32'hE0812003, 32'hE0812003, 32'hE5912004,
                                   32'hE5012004, 32'hEB000010, 32'h0B000010,
                                   32'hE3500000};
    bit          dir_ok [NDIR] = '{1, 1, 1, 1, 1, 0, 1};
    int          dir_k  [NDIR] = '{0, 3, -1, -1, -1, -1, -1};

    int          plan[$];
    int          idx, wcnt, kcur, ksum, cyc, base, force_k, ninst;
    logic [31:0] cur_ir;
    logic        cur_ok;

    // Pick the next instruction and lay out its phases from the ISA rules.
    task automatic new_instr();
        if (ninst < NDIR) begin
            cur_ir  = dir_ir[ninst];
            cur_ok  = dir_ok[ninst];
            force_k = dir_k[ninst];
        end else begin
            cur_ir  = $urandom;
            cur_ok  = ($urandom_range(0, 4) != 0);
            force_k = -1;
        end
        plan = '{P_F0, P_F1, P_F2, P_DEC};
        if (!cur_ok) begin
            base = 4;
        end else if (cur_ir[27:26] == 2'b00) begin
            plan.push_back(P_DP);
            base = 5;
        end else if (cur_ir[27:26] == 2'b01) begin
            plan.push_back(P_LSA);
            if (cur_ir[20]) begin
                plan.push_back(P_LDW);
                plan.push_back(P_LWB);
            end else begin
                plan.push_back(P_STD);
                plan.push_back(P_STW);
            end
            base = 7;
        end else if (cur_ir[27:25] == 3'b101) begin
            if (cur_ir[24]) begin
                plan.push_back(P_BL);
                base = 6;
            end else begin
                base = 5;
            end
            plan.push_back(P_BR);
        end else begin
            base = 4;
        end
        idx  = 0;
        wcnt = 0;
        ksum = 0;
        cyc  = 0;
    endtask

    initial begin
        int  ph;
        bit  seen;
        rst_n        = 1'b0;
        ir           = 32'd0;
        cond_ok      = 1'b0;
        bus.mem_done = 1'b0;
        ninst        = 0;
        kcur         = 0;

        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", dut_vec(), 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        check("idle_outs", dut_vec(), 32'd0);

        new_instr();
        for (int c = 0; c < 20000 && ninst < NINST; c++) begin
            @(posedge clk);
            #1;
            ir      = cur_ir;
            cond_ok = cur_ok;
            ph      = plan[idx];
            if (is_wait(ph)) begin
                if (wcnt == 0)
                    kcur = (force_k >= 0) ? force_k : $urandom_range(0, 3);
                bus.mem_done = (wcnt >= kcur);
            end else begin
                bus.mem_done = 1'($urandom_range(0, 1));
            end
            #4;
            check($sformatf("state@%0d ir=%h", ph, cur_ir), 32'(state), 32'(ph));
            check($sformatf("outs@%0d ir=%h", ph, cur_ir), dut_vec(),
                  exp_vec(ph, cur_ir, bus.mem_done));
            cyc++;
            if (is_wait(ph) && !bus.mem_done) begin
                wcnt++;
            end else begin
                if (is_wait(ph)) ksum += wcnt;
                wcnt = 0;
                idx++;
            end
            if (idx == plan.size()) begin
                check($sformatf("latency ir=%h", cur_ir), 32'(cyc), 32'(base + ksum));
                ninst++;
                new_instr();
            end
        end
        check("inst_budget", 32'(ninst), 32'(NINST));

        // Asynchronous reset in the middle of a load wait.
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            ir           = 32'hE5912004;
            cond_ok      = 1'b1;
            bus.mem_done = !(state == 4'd6 || state == 4'd7);
            if (state == 4'd7) begin
                seen = 1;
                break;
            end
        end
        check("ld_wait_reached", 32'(seen), 32'd1);
        #1;
        check("ld_wait_req", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_req", 32'(bus.mem_req), 32'd0);
        check("async_outs", dut_vec(), 32'd0);
        @(posedge clk);
        #2;
        check("held_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("restart_state", 32'(state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
